// File: rtl/simple_dpram_if.sv
// Port bundle for simple_dpram: write port 2, registered read port 1.
interface simple_dpram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              w_en;
    logic              r_en;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] data_in2;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;

    modport master (
        output w_en, r_en, addr1, addr2, data_in2,
        input  data_out, rd_valid
    );

    modport slave (
        input  w_en, r_en, addr1, addr2, data_in2,
        output data_out, rd_valid
    );
endinterface

// File: rtl/simple_dpram.sv
// Single-clock simple dual-port RAM, write-first on address collision.
// Array and read outputs are cleared by the asynchronous active-low reset.
module simple_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input logic           clk,
    input logic           rst,
    simple_dpram_if.slave bus
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;

    // Reading from the post-write view gives write-first on collision.
    always_comb begin
        mem_d   = mem_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (bus.w_en) begin
            mem_d[bus.addr2] = bus.data_in2;
        end
        if (bus.r_en) begin
            data_d  = mem_d[bus.addr1];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.rd_valid = valid_q;

endmodule

// File: tb/tb_simple_dpram.sv
// Directed self-checking bench for simple_dpram.
module tb_simple_dpram;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    simple_dpram_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    simple_dpram #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_en     = 1'b0;
        bus.r_en     = 1'b0;
        bus.addr1    = '0;
        bus.addr2    = '0;
        bus.data_in2 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got=%h exp=00", bus.data_out);
        end
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", bus.rd_valid);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.r_en  = 1'b1;
            bus.addr1 = 3'(i);
            step();
            checks++;
            if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL clear_read[%0d] got=%h/%b exp=00/1",
                         i, bus.data_out, bus.rd_valid);
            end
        end
        bus.r_en = 1'b0;
        step();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop got=%b exp=0", bus.rd_valid);
        end
    endtask

    task automatic test_write_read();
        bus.w_en     = 1'b1;
        bus.addr2    = 3'd0;
        bus.data_in2 = 8'hDD;
        step();
        bus.w_en  = 1'b0;
        bus.r_en  = 1'b1;
        bus.addr1 = 3'd0;
        step();
        bus.r_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'hDD || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL write_read got=%h/%b exp=dd/1",
                     bus.data_out, bus.rd_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            bus.w_en     = 1'b1;
            bus.addr2    = 3'(i);
            bus.data_in2 = 8'(8'h10 + i);
            step();
        end
        bus.w_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.r_en  = 1'b1;
            bus.addr1 = 3'(i);
            step();
            checks++;
            if (bus.data_out !== 8'(8'h10 + i) || bus.rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL fill_read[%0d] got=%h/%b exp=%h/1",
                         i, bus.data_out, bus.rd_valid, 8'(8'h10 + i));
            end
        end
        bus.r_en = 1'b0;
    endtask

    task automatic test_collision();
        bus.w_en     = 1'b1;
        bus.addr2    = 3'd3;
        bus.data_in2 = 8'hAE;
        bus.r_en     = 1'b1;
        bus.addr1    = 3'd3;
        step();
        bus.w_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'hAE || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL collision got=%h/%b exp=ae/1",
                     bus.data_out, bus.rd_valid);
        end
        step();
        bus.r_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'hAE) begin
            errors++;
            $display("FAIL collision_mem got=%h exp=ae", bus.data_out);
        end
    endtask

    task automatic test_independent();
        bus.w_en     = 1'b1;
        bus.addr2    = 3'd6;
        bus.data_in2 = 8'h66;
        bus.r_en     = 1'b1;
        bus.addr1    = 3'd2;
        step();
        bus.w_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'h12) begin
            errors++;
            $display("FAIL indep_read got=%h exp=12", bus.data_out);
        end
        bus.addr1 = 3'd6;
        step();
        bus.r_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'h66) begin
            errors++;
            $display("FAIL indep_write got=%h exp=66", bus.data_out);
        end
    endtask

    task automatic test_hold();
        bus.r_en  = 1'b1;
        bus.addr1 = 3'd1;
        step();
        checks++;
        if (bus.data_out !== 8'h11) begin
            errors++;
            $display("FAIL hold_first got=%h exp=11", bus.data_out);
        end
        bus.r_en     = 1'b0;
        bus.w_en     = 1'b1;
        bus.addr2    = 3'd1;
        bus.data_in2 = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.data_out !== 8'h11 || bus.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got=%h/%b exp=11/0",
                         i, bus.data_out, bus.rd_valid);
            end
        end
        bus.w_en  = 1'b0;
        bus.r_en  = 1'b1;
        bus.addr1 = 3'd1;
        step();
        bus.r_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'h55) begin
            errors++;
            $display("FAIL hold_after got=%h exp=55", bus.data_out);
        end
    endtask

    task automatic test_async_reset();
        bus.r_en  = 1'b1;
        bus.addr1 = 3'd5;
        step();
        checks++;
        if (bus.data_out !== 8'h15 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got=%h/%b exp=15/1",
                     bus.data_out, bus.rd_valid);
        end
        bus.w_en     = 1'b1;
        bus.addr2    = 3'd5;
        bus.data_in2 = 8'h99;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%h/%b exp=00/0",
                     bus.data_out, bus.rd_valid);
        end
        step();
        checks++;
        if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority got=%h/%b exp=00/0",
                     bus.data_out, bus.rd_valid);
        end
        #2;
        rst      = 1'b1;
        bus.w_en = 1'b0;
        bus.r_en = 1'b1;
        bus.addr1 = 3'd5;
        step();
        checks++;
        if (bus.data_out !== 8'h00 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset5 got=%h/%b exp=00/1",
                     bus.data_out, bus.rd_valid);
        end
        bus.addr1 = 3'd1;
        step();
        bus.r_en = 1'b0;
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL post_reset1 got=%h exp=00", bus.data_out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_fill();
        test_collision();
        test_independent();
        test_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
